solve_seq: RTL and testbench
============================

Name: solve_seq

Overview:
- Top-level sequencer between the puzzle-solver CPU and the 7-segment display path.
- Debounces the five board buttons and issues a start handshake to the solver.
- Captures the solver's move count and packed move list, then steps through the solution manually or automatically.
- Drives the completion flag, move index and current move code that the display block renders.

Parameters:
- MAX_MOVES, 13, capacity of the move list (2 bits per move).
- CNT_W, 5, width of the move count and move index.
- DEB_CYC, 1000, clock cycles a synchronized button level must hold stable to be accepted.
- STEP_CYC, 25000000, auto-play interval in cycles.
- TIMEOUT_CYC, 100000000, maximum cycles to wait for slv_done.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- btn  in  5  raw buttons: [0] solve, [1] play/pause, [2] home, [3] prev, [4] next
- slv_start  out  1  one-cycle solve request to the solver
- slv_done  in  1  one-cycle solver completion pulse
- slv_ok  in  1  solution found; sampled with slv_done
- slv_cnt  in  CNT_W  move count; sampled with slv_done
- slv_ord  in  2*MAX_MOVES  packed moves; move i is at bits [2i+1:2i]. Codes: 00 right, 01 up, 10 down, 11 left
- comp  out  1  valid solution held
- cnt  out  CNT_W  captured move count
- num  out  CNT_W  current move index
- move  out  2  code of move num
- move_vld  out  1  comp and num<cnt
- playing  out  1  auto-play active
- err  out  1  solver failure or timeout

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) returns the block to IDLE:
  - all outputs 0; captured ord 0; all counters 0; debouncers cleared to "released".
  - Reset mid-solve abandons the request; a late slv_done is ignored in IDLE.
- Button input path:
  - Each btn bit passes through a 2-FF synchronizer, then a stability counter.
  - The debounced level updates only after DEB_CYC consecutive equal samples.
  - A press event is a 1-cycle pulse on the debounced 0->1 edge.
  - A held button produces exactly one event.
- States: IDLE, REQ, WAIT, SHOW, PLAY, FAIL.
- IDLE:
  - solve event -> REQ.
  - All other events are ignored.
- REQ:
  - slv_start=1 for exactly this one cycle.
  - Clear comp, err, num, cnt and the timeout counter.
  - Next state WAIT.
- WAIT:
  - The timeout counter increments each cycle.
  - slv_done with slv_ok=1: cnt<=min(slv_cnt,MAX_MOVES), ord<=slv_ord, comp<=1, num<=0 -> SHOW.
  - slv_done with slv_ok=0, or counter reaching TIMEOUT_CYC-1 -> FAIL, err<=1.
  - slv_done wins if it coincides with timeout.
  - Button events are ignored.
- SHOW:
  - next: num++ if num<cnt.
  - prev: num-- if num>0.
  - home: num<=0.
  - play: -> PLAY with step timer cleared, but only if num<cnt; otherwise ignored.
  - solve: -> REQ (re-solve).
- PLAY:
  - playing=1; the step timer counts 0..STEP_CYC-1.
  - When the timer wraps, num++. If the new num==cnt -> SHOW (playback stops at the end).
  - play -> SHOW (pause, num kept).
  - prev, next or home: apply as in SHOW, clear the step timer, remain in PLAY.
  - If next brings num to cnt -> SHOW.
  - solve -> REQ.
- FAIL:
  - comp=0, err=1.
  - solve -> REQ, which clears err.
  - All else ignored.
- Simultaneous debounced events are resolved in priority order solve > home > play > prev > next; the lower-priority events are dropped.
- move and move_vld are combinational from num and the captured ord.
  - move_vld=0 gives move=00.
  - When cnt=0 (already solved), SHOW stays with num=0 and move_vld=0.
- Index arithmetic never wraps: num stays within 0..cnt.
- num, cnt, comp and playing are registered and change only on clk edges.

Test Plan:
- Bench parameters DEB_CYC=4, STEP_CYC=8, TIMEOUT_CYC=32.
- Scenario 1: rst=1 then 0; pulse btn[0] for 10 cycles -> one slv_start pulse ~7 cycles after the press, not repeated while held. Solver returns slv_done, slv_ok=1, slv_cnt=3, slv_ord=...10_01_11 -> comp=1, cnt=3, num=0, move=11.
- Scenario 2: from scenario 1, press next 4 times -> num 1,2,3,3 and move 01,10,00 (move_vld=0 at num=3). Press prev 5 times -> num floors at 0. A 2-cycle glitch on btn[4] causes no change.
- Scenario 3: press play at num=0 with cnt=3 -> num increments every 8 cycles and reaches 3; playing falls to 0 on the same edge num becomes 3. Play at num=3 is ignored.
- Scenario 4: press solve with slv_done never returned -> err=1 and FAIL after 32 cycles in WAIT. Next solve press -> slv_start, err=0. slv_done with slv_ok=0 -> FAIL.
- Scenario 5: slv_cnt=20 -> cnt clamps to 13. Assert rst during PLAY -> all outputs 0 next cycle; a following stray slv_done leaves comp=0.
- Scenario 6: during PLAY, press btn[2] and btn[4] in the same debounced cycle -> home wins, num=0, step timer restarts, playing stays 1.

Source files
------------

// File: rtl/solve_seq.sv
// solve_seq: debounced button sequencer that requests a solve, captures the move list and steps through it
// Ports: clk/rst (sync, active-high); btn[4:0] raw buttons {next,prev,home,play,solve};
//        slv_start/slv_done/slv_ok/slv_cnt/slv_ord solver handshake and result;
//        comp/cnt/num/move/move_vld/playing/err display-side status.
module solve_seq #(
  parameter int MAX_MOVES   = 13,
  parameter int CNT_W       = 5,
  parameter int DEB_CYC     = 1000,
  parameter int STEP_CYC    = 25000000,
  parameter int TIMEOUT_CYC = 100000000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [4:0]             btn,
  output logic                   slv_start,
  input  logic                   slv_done,
  input  logic                   slv_ok,
  input  logic [CNT_W-1:0]       slv_cnt,
  input  logic [2*MAX_MOVES-1:0] slv_ord,
  output logic                   comp,
  output logic [CNT_W-1:0]       cnt,
  output logic [CNT_W-1:0]       num,
  output logic [1:0]             move,
  output logic                   move_vld,
  output logic                   playing,
  output logic                   err
);
  localparam int DW = $clog2(DEB_CYC + 1);
  localparam int SW = $clog2(STEP_CYC + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] MAXC = CNT_W'(MAX_MOVES);
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_SHOW, S_PLAY, S_FAIL} state_t;
  state_t                 st_q;
  logic [4:0]             s1_q, s2_q, deb_q, ev_q;
  logic [DW-1:0]          dc_q [5];
  logic [SW-1:0]          step_q;
  logic [TW-1:0]          to_q;
  logic [2*MAX_MOVES-1:0] ord_q;
  logic [CNT_W-1:0]       num1;
  logic                   sol, hom, ply, prv, nxt;
  // Debounced level only follows the synchronized input after DEB_CYC equal samples;
  // the press pulse fires on the accepted 0->1 transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q  <= '0;
      s2_q  <= '0;
      deb_q <= '0;
      ev_q  <= '0;
      for (int k = 0; k < 5; k++) dc_q[k] <= '0;
    end else begin
      s1_q <= btn;
      s2_q <= s1_q;
      ev_q <= '0;
      for (int k = 0; k < 5; k++)
        if (s2_q[k] == deb_q[k]) dc_q[k] <= '0;
        else if (dc_q[k] == DW'(DEB_CYC - 1)) begin
          dc_q[k]  <= '0;
          deb_q[k] <= s2_q[k];
          ev_q[k]  <= s2_q[k];
        end else dc_q[k] <= dc_q[k] + 1'b1;
    end
  end
  // Priority solve > home > play > prev > next; lower ones are dropped.
  always_comb begin
    sol  = ev_q[0];
    hom  = ev_q[2] & ~ev_q[0];
    ply  = ev_q[1] & ~ev_q[0] & ~ev_q[2];
    prv  = ev_q[3] & ~|ev_q[2:0];
    nxt  = ev_q[4] & ~|ev_q[3:0];
    num1 = num + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q      <= S_IDLE;
      slv_start <= 1'b0;
      comp      <= 1'b0;
      cnt       <= '0;
      num       <= '0;
      playing   <= 1'b0;
      err       <= 1'b0;
      ord_q     <= '0;
      to_q      <= '0;
      step_q    <= '0;
    end else begin
      slv_start <= 1'b0;
      case (st_q)
        S_IDLE, S_FAIL: if (sol) begin
          st_q      <= S_REQ;
          slv_start <= 1'b1;
        end
        S_REQ: begin
          comp <= 1'b0;
          err  <= 1'b0;
          num  <= '0;
          cnt  <= '0;
          to_q <= '0;
          st_q <= S_WAIT;
        end
        S_WAIT:
          if (slv_done) begin
            if (slv_ok) begin
              cnt   <= slv_cnt > MAXC ? MAXC : slv_cnt;
              ord_q <= slv_ord;
              comp  <= 1'b1;
              num   <= '0;
              st_q  <= S_SHOW;
            end else begin
              err  <= 1'b1;
              st_q <= S_FAIL;
            end
          end else if (to_q == TW'(TIMEOUT_CYC - 1)) begin
            err  <= 1'b1;
            st_q <= S_FAIL;
          end else to_q <= to_q + 1'b1;
        S_SHOW:
          if (sol) begin
            st_q      <= S_REQ;
            slv_start <= 1'b1;
          end else if (hom) num <= '0;
          else if (ply) begin
            if (num < cnt) begin
              st_q    <= S_PLAY;
              playing <= 1'b1;
              step_q  <= '0;
            end
          end else if (prv) begin
            if (num != '0) num <= num - 1'b1;
          end else if (nxt && num < cnt) num <= num1;
        S_PLAY:
          if (sol) begin
            st_q      <= S_REQ;
            slv_start <= 1'b1;
            playing   <= 1'b0;
          end else if (ply) begin
            st_q    <= S_SHOW;
            playing <= 1'b0;
          end else if (hom | prv | nxt) begin
            step_q <= '0;
            if (hom) num <= '0;
            else if (prv) begin
              if (num != '0) num <= num - 1'b1;
            end else begin
              num <= num1;
              if (num1 == cnt) begin
                st_q    <= S_SHOW;
                playing <= 1'b0;
              end
            end
          end else if (step_q == SW'(STEP_CYC - 1)) begin
            step_q <= '0;
            num    <= num1;
            if (num1 == cnt) begin
              st_q    <= S_SHOW;
              playing <= 1'b0;
            end
          end else step_q <= step_q + 1'b1;
        default: st_q <= S_IDLE;
      endcase
    end
  end
  always_comb begin
    move_vld = comp && num < cnt;
    move     = 2'b00;
    for (int k = 0; k < MAX_MOVES; k++)
      if (move_vld && num == CNT_W'(k)) move = ord_q[2*k +: 2];
  end
endmodule

// File: tb/tb_solve_seq.sv
// tb_solve_seq: vector tables, corner sequences and randomized model checks for solve_seq
module tb_solve_seq;
  localparam int TO = 32;
  localparam int ST = 8;
  logic        clk, rst, slv_start, slv_done, slv_ok, comp, move_vld, playing, err;
  logic [4:0]  btn, slv_cnt, cnt, num;
  logic [25:0] slv_ord;
  logic [1:0]  move;
  int tests, fails, starts;
  bit saw_play;
  solve_seq #(.DEB_CYC(4), .STEP_CYC(ST), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .btn(btn), .slv_start(slv_start), .slv_done(slv_done),
    .slv_ok(slv_ok), .slv_cnt(slv_cnt), .slv_ord(slv_ord), .comp(comp), .cnt(cnt),
    .num(num), .move(move), .move_vld(move_vld), .playing(playing), .err(err));
  initial clk = 0;
  always #5 clk = ~clk;
  always @(negedge clk) if (slv_start) starts++;
  typedef struct {logic [4:0] b; int n; logic [1:0] m; logic v;} vec_t;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic press(logic [4:0] m);
    saw_play = 0;
    btn = m;
    repeat (10) begin tick; saw_play |= playing; end
    btn = 0;
    repeat (10) begin tick; saw_play |= playing; end
  endtask
  task automatic do_solve(bit send, bit ok, logic [4:0] c, logic [25:0] o);
    int s0 = starts;
    btn = 5'b00001;
    repeat (10) tick;
    btn = 0;
    repeat (3) tick;
    check("start_once", starts - s0, 1);
    if (send) begin
      slv_ok = ok; slv_cnt = c; slv_ord = o; slv_done = 1;
      tick;
      slv_done = 0; slv_ok = 0;
      tick;
    end
  endtask
  function automatic logic [1:0] ref_move(logic [25:0] o, int n, int c);
    logic [25:0] t = o >> (2 * n);
    return (n < c) ? t[1:0] : 2'b00;
  endfunction
  initial begin
    vec_t tab [9];
    int ts, te, tp, k, th, tn, nn, n0, cm, nm;
    int t [3];
    bit pl3, allp;
    logic [4:0] pn;
    logic [25:0] o;
    logic [4:0] c;
    logic [2:0] x;
    logic [4:0] m;
    tab[0] = '{5'b10000, 1, 2'b01, 1'b1};
    tab[1] = '{5'b10000, 2, 2'b10, 1'b1};
    tab[2] = '{5'b10000, 3, 2'b00, 1'b0};
    tab[3] = '{5'b10000, 3, 2'b00, 1'b0};
    tab[4] = '{5'b01000, 2, 2'b10, 1'b1};
    tab[5] = '{5'b01000, 1, 2'b01, 1'b1};
    tab[6] = '{5'b01000, 0, 2'b11, 1'b1};
    tab[7] = '{5'b01000, 0, 2'b11, 1'b1};
    tab[8] = '{5'b01000, 0, 2'b11, 1'b1};
    tests = 0; fails = 0; starts = 0;
    rst = 1; btn = 0; slv_done = 0; slv_ok = 0; slv_cnt = 0; slv_ord = 0;
    repeat (3) tick;
    rst = 0;
    tick;
    check("rst_comp", comp, 0);
    check("rst_cnt", cnt, 0);
    check("rst_num", num, 0);
    check("rst_err", err, 0);
    check("rst_play", playing, 0);
    check("rst_vld", {move_vld, move}, 0);
    // Scenario 1
    do_solve(1, 1, 5'd3, 26'b100111);
    check("s1_comp", comp, 1);
    check("s1_cnt", cnt, 3);
    check("s1_num", num, 0);
    check("s1_move", move, 2'b11);
    // Scenario 2: table of next/prev presses
    for (int i = 0; i < 9; i++) begin
      press(tab[i].b);
      check($sformatf("tab%0d_num", i), num, tab[i].n);
      check($sformatf("tab%0d_move", i), move, tab[i].m);
      check($sformatf("tab%0d_vld", i), move_vld, tab[i].v);
    end
    btn = 5'b10000;
    repeat (2) tick;
    btn = 0;
    repeat (12) tick;
    check("glitch_num", num, 0);
    // Scenario 3: auto-play to the end
    tp = -1; k = 0; pl3 = 1; pn = num;
    btn = 5'b00010;
    for (int i = 0; i < 60; i++) begin
      if (i == 10) btn = 0;
      tick;
      if (playing && tp < 0) tp = i;
      if (num != pn && k < 3) begin
        t[k] = i; k++;
        if (num == 3) pl3 = playing;
      end
      pn = num;
    end
    check("play_started", tp >= 0, 1);
    check("play_steps", k, 3);
    check("play_t1", t[0] - tp, ST);
    check("play_t2", t[1] - t[0], ST);
    check("play_t3", t[2] - t[1], ST);
    check("play_stop_edge", pl3, 0);
    check("play_end_num", num, 3);
    press(5'b00010);
    check("play_at_end", saw_play, 0);
    // Scenario 4: timeout, then solver failure
    ts = -1; te = -1;
    btn = 5'b00001;
    for (int i = 0; i < 80; i++) begin
      if (i == 10) btn = 0;
      tick;
      if (slv_start && ts < 0) ts = i;
      if (err && te < 0) te = i;
    end
    check("to_started", ts >= 0, 1);
    check("to_latency", te - ts, TO + 1);
    check("to_comp", comp, 0);
    do_solve(0, 0, 0, 0);
    check("resolve_err_clr", err, 0);
    slv_done = 1; slv_ok = 0;
    tick;
    slv_done = 0;
    tick;
    check("nok_err", err, 1);
    check("nok_comp", comp, 0);
    // Scenario 5: clamp, reset during play, stray done
    do_solve(1, 1, 5'd20, 26'h2AB_CDEF);
    check("clamp_cnt", cnt, 13);
    btn = 5'b00010;
    repeat (8) tick;
    check("s5_playing", playing, 1);
    rst = 1; btn = 0;
    tick;
    check("midrst_out", {slv_start, comp, cnt, num, move, move_vld, playing, err}, 0);
    rst = 0;
    tick;
    k = starts;
    slv_done = 1; slv_ok = 1; slv_cnt = 3;
    tick;
    slv_done = 0; slv_ok = 0;
    repeat (3) tick;
    check("stray_comp", comp, 0);
    check("stray_cnt", cnt, 0);
    check("stray_start", starts - k, 0);
    // Scenario 6: home and next together during play
    do_solve(1, 1, 5'd13, 26'h1234567);
    press(5'b10000);
    press(5'b10000);
    check("s6_num", num, 2);
    press(5'b00010);
    check("s6_playing", playing, 1);
    th = -1; tn = -1; nn = -1; allp = 1;
    btn = 5'b10100;
    for (int i = 0; i < 40; i++) begin
      if (i == 10) btn = 0;
      tick;
      allp &= playing;
      if (th < 0 && num == 0) th = i;
      else if (th >= 0 && tn < 0 && num != 0) begin tn = i; nn = num; end
    end
    check("home_seen", th >= 0, 1);
    check("home_restart", tn - th, ST);
    check("home_next_num", nn, 1);
    check("home_playing", allp, 1);
    press(5'b00010);
    check("pause_playing", playing, 0);
    n0 = num;
    repeat (20) tick;
    check("pause_hold", num, n0);
    // Randomized SHOW navigation against the index model
    for (int r = 0; r < 3; r++) begin
      c = (r == 0) ? 5'd0 : 5'($urandom_range(1, 15));
      o = 26'($urandom);
      do_solve(1, 1, c, o);
      cm = (c > 13) ? 13 : int'(c);
      nm = 0;
      check("rnd_cnt", cnt, cm);
      check("rnd_comp", comp, 1);
      for (int j = 0; j < 20; j++) begin
        x = 3'($urandom_range(1, 7));
        m = {x, 2'b00};
        press(m);
        if (m[2]) nm = 0;
        else if (m[3]) nm = (nm > 0) ? nm - 1 : 0;
        else if (nm < cm) nm++;
        check("rnd_num", num, nm);
        check("rnd_vld", move_vld, nm < cm);
        check("rnd_move", move, ref_move(o, nm, cm));
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
